// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) for the timing generator and display stages.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered sync, blank and frame decode.
// Every output is decoded from the next position so all outputs align with DrawX/DrawY.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic               vga_clk,
  input  logic               reset,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               frame_start,
  output logic [7:0]         frame_count
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEGIN = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEGIN = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  logic               line_wrap;
  logic               frame_entry;

  // Wrapping on >= rather than == keeps a corrupted count from running past the total.
  always_comb begin
    line_wrap = (DrawX >= H_LAST);
    x_next    = line_wrap ? '0 : DrawX + COORD_W'(1);
    y_next    = DrawY;
    if (line_wrap) begin
      y_next = (DrawY >= V_LAST) ? '0 : DrawY + COORD_W'(1);
    end
    frame_entry = (x_next == '0) && (y_next == '0);
  end

  // Reset parks the raster on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= x_next;
      DrawY       <= y_next;
      hs          <= !((x_next >= HS_BEGIN) && (x_next < HS_END));
      vs          <= !((y_next >= VS_BEGIN) && (y_next < VS_END));
      blank       <= (x_next < H_VIS) && (y_next < V_VIS);
      frame_start <= frame_entry;
      if (frame_entry) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-size and reduced-size instances checked against an
// index-based raster model through per-instance expectation queues.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk;
  logic reset;

  logic [9:0] x_big, y_big, x_sml, y_sml;
  logic       hs_big, vs_big, blank_big, fs_big;
  logic       hs_sml, vs_sml, blank_sml, fs_sml;
  logic [7:0] fc_big, fc_sml;

  vga_timing_gen dut_big (
    .vga_clk(clk), .reset(reset), .DrawX(x_big), .DrawY(y_big), .hs(hs_big), .vs(vs_big),
    .blank(blank_big), .frame_start(fs_big), .frame_count(fc_big)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_sml (
    .vga_clk(clk), .reset(reset), .DrawX(x_sml), .DrawY(y_sml), .hs(hs_sml), .vs(vs_sml),
    .blank(blank_sml), .frame_start(fs_sml), .frame_count(fc_sml)
  );

  obs_t obs_big, obs_sml;
  assign obs_big = {x_big, y_big, hs_big, vs_big, blank_big, fs_big, fc_big};
  assign obs_sml = {x_sml, y_sml, hs_sml, vs_sml, blank_sml, fs_sml, fc_sml};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b fc=%0d, want x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b fc=%0d",
               name, act.x, act.y, act.hs, act.vs, act.blank, act.fs, act.fc,
               exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.fs, exp.fc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Expected outputs k edges after reset release, derived from the raster index.
  function automatic obs_t model(input int k, input int ha, input int hfp, input int hsy, input int hbp,
                                 input int va, input int vfp, input int vsy, input int vbp);
    obs_t o;
    int ht, vt, per, pos, x, y;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    per = ht * vt;
    pos = k % per;
    x = pos % ht;
    y = pos / ht;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.hs    = !((x >= ha + hfp) && (x < ha + hfp + hsy));
    o.vs    = !((y >= va + vfp) && (y < va + vfp + vsy));
    o.blank = (x < ha) && (y < va);
    o.fs    = (pos == 0);
    o.fc    = 8'((k / per + 1) % 256);
    return o;
  endfunction

  obs_t q_big[$];
  obs_t q_sml[$];
  bit   run = 1'b0;
  int   phase = 0;
  int   k = 0;

  // Stimulus side: each active edge after release queues the response it should produce.
  always @(posedge clk) begin
    if (run) begin
      q_big.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33));
      q_sml.push_back(model(k, 8, 1, 2, 1, 4, 1, 1, 1));
      k++;
    end
  end

  int hs_low_line0  = 0;
  int blank_line0   = 0;
  int vs_low_frame0 = 0;
  int late_blank    = 0;
  int sc            = 0;
  int prev_pulse    = 0;
  bit have_prev     = 1'b0;
  int n_pulse       = 0;
  int pulse_fc[300];

  // Monitor: pops one expectation per instance per clock and gathers line/frame statistics.
  always @(negedge clk) begin
    obs_t e;
    if (q_big.size() > 0) begin
      e = q_big.pop_front();
      check_obs("big_raster", obs_big, e);
      if (phase == 1 && y_big == 10'd0) begin
        if (!hs_big) hs_low_line0++;
        if (blank_big) blank_line0++;
      end
    end
    if (q_sml.size() > 0) begin
      e = q_sml.pop_front();
      check_obs("small_raster", obs_sml, e);
      if (phase == 1) begin
        if (sc < 84 && !vs_sml) vs_low_frame0++;
        if (y_sml >= 10'd4 && blank_sml) late_blank++;
        if (fs_sml) begin
          if (have_prev) check_int("small_frame_period", sc - prev_pulse, 84);
          have_prev  = 1'b1;
          prev_pulse = sc;
          if (n_pulse < 300) pulse_fc[n_pulse] = fc_sml;
          n_pulse++;
        end
        sc++;
      end
    end
  end

  obs_t rst_big, rst_sml;

  initial begin
    rst_big = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    rst_sml = {10'd11, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_obs("reset_big", obs_big, rst_big);
    check_obs("reset_small", obs_sml, rst_sml);

    @(negedge clk);
    #1;
    reset = 1'b0;
    k = 0;
    phase = 1;
    run = 1'b1;
    repeat (21650) @(posedge clk);

    // Mid-frame reset asserted between edges: outputs must react without a clock edge.
    @(negedge clk);
    #1;
    reset = 1'b1;
    run = 1'b0;
    phase = 2;
    #1;
    check_obs("async_reset_big", obs_big, rst_big);
    check_obs("async_reset_small", obs_sml, rst_sml);
    repeat (3) @(posedge clk);
    #1;
    check_obs("held_reset_big", obs_big, rst_big);
    check_obs("held_reset_small", obs_sml, rst_sml);

    @(negedge clk);
    #1;
    reset = 1'b0;
    k = 0;
    run = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    #1;
    run = 1'b0;

    check_int("hs_low_cycles_line0", hs_low_line0, 96);
    check_int("blank_cycles_line0", blank_line0, 640);
    check_int("small_vs_low_cycles", vs_low_frame0, 12);
    check_int("small_blank_below_active", late_blank, 0);
    check_int("small_pulse_count", n_pulse, 258);
    check_int("fc_at_pulse_1", pulse_fc[0], 1);
    check_int("fc_at_pulse_255", pulse_fc[254], 255);
    check_int("fc_at_pulse_256", pulse_fc[255], 0);
    check_int("fc_at_pulse_257", pulse_fc[256], 1);
    check_int("queue_drained", q_big.size() + q_sml.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
